// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use, redirect and dmem-wait hazards,
// a wait-timeout watchdog, and stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MAX_WAIT   = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  use_rs1_ID,
  input  logic                  use_rs2_ID,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic                  MemRead_EX,
  input  logic                  RegWrite_EX,
  input  logic                  branch_taken_EX,
  input  logic                  Jump_EX,
  input  logic                  dmem_req_MEM,
  input  logic                  dmem_ready_MEM,
  output logic                  pc_we,
  output logic                  pc_redirect,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_we,
  output logic                  id_ex_flush,
  output logic                  ex_mem_we,
  output logic                  mem_wb_flush,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;

  logic mem_busy;
  logic redirect;
  logic load_use;

  assign mem_busy = dmem_req_MEM && !dmem_ready_MEM && (state_q != HALT);
  assign redirect = branch_taken_EX || Jump_EX;
  assign load_use = MemRead_EX && RegWrite_EX && (rd_EX != '0) &&
                    ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                     (use_rs2_ID && (rs2_ID == rd_EX)));

  // State register, watchdog and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        if (dmem_req_MEM && !dmem_ready_MEM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_MEM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_W'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d       = HALT;
          mem_timeout_d = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // Pipeline control outputs, highest priority first
  always_comb begin
    pc_we        = 1'b1;
    pc_redirect  = 1'b0;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    mem_wb_flush = 1'b0;
    if (rst) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (mem_busy || (state_q == HALT)) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (pc_redirect && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MAX_WAIT=4).
module tb_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;

  // {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush}
  localparam logic [7:0] C_ZERO = 8'b0000_0000;
  localparam logic [7:0] C_DEF  = 8'b1010_1010;
  localparam logic [7:0] C_LU   = 8'b0000_1110;
  localparam logic [7:0] C_RED  = 8'b1111_1110;
  localparam logic [7:0] C_FRZ  = 8'b0000_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rs1_ID, rs2_ID, rd_EX;
  logic          use_rs1_ID, use_rs2_ID, MemRead_EX, RegWrite_EX;
  logic          branch_taken_EX, Jump_EX, dmem_req_MEM, dmem_ready_MEM;
  logic          pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic          ex_mem_we, mem_wb_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned stall_m = 0;
  int unsigned flush_m = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  hazard_ctrl #(.REG_ADDR_W(RW), .MAX_WAIT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
    .branch_taken_EX(branch_taken_EX), .Jump_EX(Jump_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready_MEM(dmem_ready_MEM),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] ctrl_now();
    return {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_flush};
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Pop the oldest expectation and compare against the live control outputs
  task automatic pop_cmp();
    logic [7:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, CW'(ctrl_now()), CW'(e));
    if (!rst && !e[7]) stall_m++;
    if (!rst && e[6])  flush_m++;
  endtask

  // One clock cycle: inputs already driven at negedge
  task automatic cyc(input string tag, input logic [7:0] exp, input logic exp_to);
    push(tag, exp);
    #1;
    pop_cmp();
    @(posedge clk);
    #1;
    chk({tag, "_stall"}, stall_cnt, CW'(stall_m));
    chk({tag, "_flush"}, flush_cnt, CW'(flush_m));
    chk({tag, "_tmo"}, CW'(mem_timeout), CW'(exp_to));
    @(negedge clk);
  endtask

  task automatic idle();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    use_rs1_ID = 0; use_rs2_ID = 0; MemRead_EX = 0; RegWrite_EX = 0;
    branch_taken_EX = 0; Jump_EX = 0; dmem_req_MEM = 0; dmem_ready_MEM = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    push("reset_out", C_ZERO);
    pop_cmp();
    chk("reset_stall", stall_cnt, '0);
    chk("reset_flush", flush_cnt, '0);
    chk("reset_tmo", CW'(mem_timeout), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    cyc("default", C_DEF, 1'b0);

    // Load-use: lw x5 ; add ..., x5 via rs2
    MemRead_EX = 1; RegWrite_EX = 1; rd_EX = 5; rs2_ID = 5; use_rs2_ID = 1;
    cyc("load_use", C_LU, 1'b0);
    idle();
    cyc("after_lu", C_DEF, 1'b0);

    // x0 destination and unused source never stall
    MemRead_EX = 1; RegWrite_EX = 1; rd_EX = 0; rs1_ID = 0; use_rs1_ID = 1;
    cyc("x0_dest", C_DEF, 1'b0);
    rd_EX = 5; rs1_ID = 5; use_rs1_ID = 0;
    cyc("unused_src", C_DEF, 1'b0);

    // Redirect wins over a simultaneous load-use
    use_rs1_ID = 1; branch_taken_EX = 1;
    cyc("redir_lu", C_RED, 1'b0);
    idle();

    // Same-cycle dmem response: no freeze
    dmem_req_MEM = 1; dmem_ready_MEM = 1;
    cyc("dmem_fast", C_DEF, 1'b0);
    dmem_ready_MEM = 0; dmem_req_MEM = 0;
    cyc("after_fast", C_DEF, 1'b0);

    // Three wait cycles with a jump frozen in EX, honoured on release
    dmem_req_MEM = 1; dmem_ready_MEM = 0; Jump_EX = 1;
    for (int i = 0; i < 3; i++) cyc("mem_wait", C_FRZ, 1'b0);
    dmem_ready_MEM = 1;
    cyc("mem_release", C_RED, 1'b0);
    idle();
    cyc("after_wait", C_DEF, 1'b0);

    // Async reset in the middle of a wait
    dmem_req_MEM = 1;
    cyc("pre_rst_wait", C_FRZ, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    stall_m = 0; flush_m = 0;
    push("rst_mid_out", C_ZERO);
    pop_cmp();
    chk("rst_mid_stall", stall_cnt, '0);
    chk("rst_mid_flush", flush_cnt, '0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    cyc("post_rst", C_DEF, 1'b0);

    // Timeout: RUN cycle plus four MEM_WAIT cycles, then HALT
    dmem_req_MEM = 1; dmem_ready_MEM = 0;
    for (int i = 0; i < 4; i++) cyc("to_wait", C_FRZ, 1'b0);
    cyc("to_last", C_FRZ, 1'b1);
    cyc("halt_hold", C_FRZ, 1'b1);
    dmem_req_MEM = 0; dmem_ready_MEM = 1; branch_taken_EX = 1;
    cyc("halt_ready", C_FRZ, 1'b1);
    idle();
    cyc("halt_idle", C_FRZ, 1'b1);

    rst = 1'b1;
    #1;
    stall_m = 0; flush_m = 0;
    chk("rst_tmo_clear", CW'(mem_timeout), '0);
    @(negedge clk);
    rst = 1'b0;
    cyc("after_halt_rst", C_DEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
